// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t         : converter FSM state encoding
//   BCD_ADJ_THRESH  : digit value at or above which +3 is applied before a shift
//   BCD_ADJ_ADD     : the double-dabble correction amount
//   min_digits()    : decimal digits needed for the largest IN_WIDTH-bit value
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Number of decimal digits in 2^in_width - 1 (valid for in_width <= 63).
  function automatic int min_digits(input int in_width);
    longint unsigned max_val;
    longint unsigned pow;
    int              d;
    max_val = (64'd1 << in_width) - 64'd1;
    pow     = 64'd10;
    d       = 1;
    for (int i = 0; i < 19; i++) begin
      if (pow <= max_val) begin
        pow = pow * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
//   value    : 4-bit BCD digit before the shift
//   adjusted : value + 3 when value >= 5, else value
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] value,
  output logic [3:0] adjusted
);

  // Digits are at most 9 here, so value + 3 never exceeds 4 bits.
  assign adjusted = (value >= BCD_ADJ_THRESH) ? value + BCD_ADJ_ADD : value;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, IN_WIDTH shifts
// per conversion, start/busy/done handshake. o_bcd changes only on
// completion or reset, so downstream digit decoders never see partial values.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_start : conversion request, accepted when not busy
//   i_bin   : unsigned binary input, captured on an accepted start
//   o_busy  : high while shifting
//   o_done  : one-cycle pulse when o_bcd has just been updated
//   o_bcd   : packed BCD, digit k (10^k) at [4k+3:4k]
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [IN_WIDTH-1:0]   i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  if (DIGITS < min_digits(IN_WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold 2^IN_WIDTH-1");
  end

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q;
  logic [SCR_W-1:0]    scratch_q;
  logic [SCR_W-1:0]    scratch_adj;
  logic [SCR_W-1:0]    scratch_shift;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;
  logic                last_shift;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .value    (scratch_q[4*k +: 4]),
      .adjusted (scratch_adj[4*k +: 4])
    );
  end

  // Adjusted scratch shifted left, binary MSB entering digit 0.
  assign scratch_shift = {scratch_adj[SCR_W-2:0], bin_q[IN_WIDTH-1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    accept     = 1'b0;
    last_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = i_start;
        if (i_start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_busy     = 1'b1;
        last_shift = (cnt_q == CNT_W'(1));
        if (last_shift) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        accept  = i_start;
        state_d = i_start ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      o_bcd     <= '0;
    end else if (accept) begin
      bin_q     <= i_bin;
      scratch_q <= '0;
      cnt_q     <= CNT_W'(IN_WIDTH);
    end else if (state_q == ST_SHIFT) begin
      bin_q     <= {bin_q[IN_WIDTH-2:0], 1'b0};
      scratch_q <= scratch_shift;
      cnt_q     <= cnt_q - CNT_W'(1);
      if (last_shift) o_bcd <= scratch_shift;
    end
  end

endmodule
